iomem_copy_dma: RTL and testbench

- Bus-initiator side of the picosoc iomem protocol.
- Takes a copy or fill command and drives iomem_valid/addr/wstrb/wdata toward iomem responders such as the video register bank and tile/texture SRAM windows.
- Copy mode: read word from src, then write it to dst, repeated for len words. Fill mode: write a constant to dst, len times.
- Lets the CPU offload tile/texture uploads to video memory.

---
 rtl/game_soc_pkg.sv | 25 ++
 rtl/iomem_beat_timer.sv | 53 +++++
 rtl/iomem_copy_dma.sv | 250 +++++++++++++++++++++++++
 tb/tb_iomem_copy_dma.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_soc_pkg.sv
// ---------------------------------------------------------------------------
// game_soc_pkg
//   Shared constants for the picosoc iomem initiators of the game SoC.
//   - ST_IDLE / ST_READ / ST_WRITE : copy-engine state encoding
//   - WSTRB_READ / WSTRB_WORD      : iomem_wstrb values for a read beat and
//                                    a full-word write beat
// ---------------------------------------------------------------------------
package game_soc_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   localparam logic [3:0] WSTRB_READ = 4'h0;
   localparam logic [3:0] WSTRB_WORD = 4'hF;

   // Byte address step between consecutive words on the iomem bus.
   localparam logic [31:0] WORD_STEP = 32'd4;

   // Forces a byte address onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
      return byte_addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/iomem_beat_timer.sv
// ---------------------------------------------------------------------------
// iomem_beat_timer
//   Counts the cycles a single iomem beat spends waiting for iomem_ready.
//   Ports:
//     clk      system clock
//     resetn   asynchronous active-low reset
//     start    clears the counter (held while no beat is on the bus)
//     run      beat is waiting this cycle (valid high, ready low)
//     expired  high in the TIMEOUT-th waiting cycle of a beat, so the
//              initiator drops valid on that edge and valid has been high
//              for exactly TIMEOUT cycles
//   Parameter:
//     TIMEOUT  waiting cycles allowed per beat (values below 1 act as 1)
// ---------------------------------------------------------------------------
module iomem_beat_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   input  logic run,
   output logic expired
);

   localparam int T_EFF = (TIMEOUT < 1) ? 1 : TIMEOUT;
   localparam int CW    = $clog2(T_EFF + 1);
   // The counter holds the number of waiting cycles already elapsed, so the
   // last permitted cycle is the one where it equals T_EFF-1.
   localparam logic [CW-1:0] LIMIT = CW'(T_EFF - 1);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (start) begin
         count_next = '0;
      end else if (run && (count_reg != LIMIT)) begin
         count_next = count_reg + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign expired = run && !start && (count_reg == LIMIT);

endmodule

// File: rtl/iomem_copy_dma.sv
// ---------------------------------------------------------------------------
// iomem_copy_dma
//   picosoc iomem bus initiator that copies len words from src to dst
//   (read beat then write beat per word) or fills dst with a constant.
//   Used by the CPU to offload tile/texture uploads into video memory.
//
//   Ports:
//     clk, resetn        clock, asynchronous active-low reset
//     cmd_valid/ready    command handshake; cmd_ready is high only in IDLE
//     cmd_fill           1 = fill, 0 = copy
//     cmd_src, cmd_dst   byte addresses, low two bits ignored
//     cmd_len            word count (0 completes immediately, no bus traffic)
//     cmd_fill_data      constant written in fill mode
//     abort              stop after the beat currently on the bus
//     busy               high while reading or writing
//     done / err         one-cycle completion / abort-or-timeout pulses
//     words_done         words written by the current or last command
//     iomem_*            picosoc iomem initiator interface
//
//   Parameters:
//     LEN_BITS  width of the word-count field
//     TIMEOUT   cycles one beat may wait for iomem_ready before giving up
// ---------------------------------------------------------------------------
module iomem_copy_dma
   import game_soc_pkg::*;
#(
   parameter int LEN_BITS = 16,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                resetn,

   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_fill,
   input  logic [31:0]         cmd_src,
   input  logic [31:0]         cmd_dst,
   input  logic [LEN_BITS-1:0] cmd_len,
   input  logic [31:0]         cmd_fill_data,
   input  logic                abort,

   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [LEN_BITS-1:0] words_done,

   output logic                iomem_valid,
   input  logic                iomem_ready,
   output logic [3:0]          iomem_wstrb,
   output logic [31:0]         iomem_addr,
   output logic [31:0]         iomem_wdata,
   input  logic [31:0]         iomem_rdata
);

   genvar gi;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]          state_reg,      state_next;
   logic                valid_reg,      valid_next;
   logic [31:0]         src_reg,        src_next;
   logic [31:0]         dst_reg,        dst_next;
   logic [LEN_BITS-1:0] len_reg,        len_next;
   logic                fill_mode_reg,  fill_mode_next;
   logic [31:0]         fill_data_reg,  fill_data_next;
   logic [31:0]         data_reg,       data_next;
   logic [LEN_BITS-1:0] words_done_reg, words_done_next;
   logic                abort_flag_reg, abort_flag_next;
   logic                done_reg,       done_next;
   logic                err_reg,        err_next;

   logic                timer_expired;
   logic                abort_seen;
   logic [LEN_BITS-1:0] words_inc;
   logic [31:0]         wdata_sel;

   // An abort raised in the same cycle as a beat's ready still ends the
   // command after that beat, so the live input is merged with the flag.
   assign abort_seen = abort_flag_reg || abort;
   assign words_inc  = words_done_reg + LEN_BITS'(1);

   // ---------------------------------------------------------------------
   // Per-beat timeout. The counter is held clear whenever valid is low,
   // which covers both IDLE and the one-cycle gap between beats.
   // ---------------------------------------------------------------------
   iomem_beat_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_beat_timer (
      .clk     (clk),
      .resetn  (resetn),
      .start   (!valid_reg),
      .run     (valid_reg && !iomem_ready),
      .expired (timer_expired)
   );

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      valid_next      = valid_reg;
      src_next        = src_reg;
      dst_next        = dst_reg;
      len_next        = len_reg;
      fill_mode_next  = fill_mode_reg;
      fill_data_next  = fill_data_reg;
      data_next       = data_reg;
      words_done_next = words_done_reg;
      abort_flag_next = abort_flag_reg;
      done_next       = 1'b0;
      err_next        = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (cmd_valid) begin
               src_next        = word_align(cmd_src);
               dst_next        = word_align(cmd_dst);
               len_next        = cmd_len;
               fill_mode_next  = cmd_fill;
               fill_data_next  = cmd_fill_data;
               words_done_next = '0;
               abort_flag_next = 1'b0;
               if (cmd_len == '0) begin
                  // Nothing to move: acknowledge and stay idle.
                  done_next = 1'b1;
               end else begin
                  state_next = cmd_fill ? ST_WRITE : ST_READ;
                  valid_next = 1'b1;
               end
            end
         end

         ST_READ, ST_WRITE: begin
            if (abort) begin
               abort_flag_next = 1'b1;
            end

            if (!valid_reg) begin
               // Gap cycle between beats: no beat is in flight, so an
               // abort can take effect without waiting for the bus.
               if (abort_seen) begin
                  state_next = ST_IDLE;
                  err_next   = 1'b1;
               end else begin
                  valid_next = 1'b1;
               end
            end else if (iomem_ready) begin
               valid_next = 1'b0;
               if (state_reg == ST_READ) begin
                  data_next = iomem_rdata;
                  src_next  = src_reg + WORD_STEP;
                  if (abort_seen) begin
                     state_next = ST_IDLE;
                     err_next   = 1'b1;
                  end else begin
                     state_next = ST_WRITE;
                  end
               end else begin
                  dst_next        = dst_reg + WORD_STEP;
                  words_done_next = words_inc;
                  // The final write completing outranks a coincident abort.
                  if (words_inc == len_reg) begin
                     state_next = ST_IDLE;
                     done_next  = 1'b1;
                  end else if (abort_seen) begin
                     state_next = ST_IDLE;
                     err_next   = 1'b1;
                  end else begin
                     state_next = fill_mode_reg ? ST_WRITE : ST_READ;
                  end
               end
            end else if (timer_expired) begin
               // Responder never answered: abandon the beat uncounted.
               valid_next = 1'b0;
               state_next = ST_IDLE;
               err_next   = 1'b1;
            end
         end

         default: begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= ST_IDLE;
         valid_reg      <= 1'b0;
         src_reg        <= '0;
         dst_reg        <= '0;
         len_reg        <= '0;
         fill_mode_reg  <= 1'b0;
         fill_data_reg  <= '0;
         data_reg       <= '0;
         words_done_reg <= '0;
         abort_flag_reg <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         valid_reg      <= valid_next;
         src_reg        <= src_next;
         dst_reg        <= dst_next;
         len_reg        <= len_next;
         fill_mode_reg  <= fill_mode_next;
         fill_data_reg  <= fill_data_next;
         data_reg       <= data_next;
         words_done_reg <= words_done_next;
         abort_flag_reg <= abort_flag_next;
         done_reg       <= done_next;
         err_reg        <= err_next;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign cmd_ready  = (state_reg == ST_IDLE);
   assign busy       = (state_reg != ST_IDLE);
   assign done       = done_reg;
   assign err        = err_reg;
   assign words_done = words_done_reg;

   assign iomem_valid = valid_reg;

   // Address, strobe and data only change on the edge that retires a beat
   // (which also drops valid), so they are stable while valid is high.
   // They are zeroed while valid is low to keep the bus quiet when idle.
   assign iomem_addr  = !valid_reg              ? 32'h0   :
                        (state_reg == ST_READ) ? src_reg : dst_reg;
   assign iomem_wstrb = (valid_reg && (state_reg == ST_WRITE)) ? WSTRB_WORD
                                                               : WSTRB_READ;

   assign wdata_sel = fill_mode_reg ? fill_data_reg : data_reg;

   // Each byte lane carries data only when its strobe is set.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wdata_lane
         assign iomem_wdata[8*gi +: 8] = iomem_wstrb[gi] ? wdata_sel[8*gi +: 8]
                                                         : 8'h00;
      end
   endgenerate

endmodule

// File: tb/tb_iomem_copy_dma.sv
// ---------------------------------------------------------------------------
// tb_iomem_copy_dma
//   Directed bench for iomem_copy_dma (LEN_BITS=16, TIMEOUT=8). A small
//   responder answers each beat one cycle after valid with
//   rdata = addr ^ 32'hA5A5_0000; a negedge monitor logs completed beats.
// ---------------------------------------------------------------------------
module tb_iomem_copy_dma;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_fill = 1'b0;
   logic [31:0] cmd_src = '0;
   logic [31:0] cmd_dst = '0;
   logic [15:0] cmd_len = '0;
   logic [31:0] cmd_fill_data = '0;
   logic        abort = 1'b0;
   logic        busy, done, err;
   logic [15:0] words_done;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr, iomem_wdata;
   logic [31:0] iomem_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   iomem_copy_dma #(.LEN_BITS(16), .TIMEOUT(8)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fill(cmd_fill),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
      .cmd_fill_data(cmd_fill_data), .abort(abort),
      .busy(busy), .done(done), .err(err), .words_done(words_done),
      .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
      .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
   );

   // Responder: ready pulse one cycle after it sees valid.
   logic resp_en = 1'b0;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
      end else if (resp_en && iomem_valid && !iomem_ready) begin
         iomem_ready <= 1'b1;
         iomem_rdata <= iomem_addr ^ 32'hA5A5_0000;
      end else begin
         iomem_ready <= 1'b0;
      end
   end

   // Monitor: beat log, pulse counters, bus stability.
   int          cyc = 0;
   logic [31:0] log_addr  [0:63];
   logic [3:0]  log_wstrb [0:63];
   logic [31:0] log_wdata [0:63];
   int          log_cyc   [0:63];
   int          log_n = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          stab_err = 0;
   logic        pv = 1'b0;
   logic [31:0] pa = '0, pd = '0;
   logic [3:0]  ps = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (err)  err_cnt  <= err_cnt + 1;
      if (iomem_valid && iomem_ready && log_n < 64) begin
         log_addr[log_n]  <= iomem_addr;
         log_wstrb[log_n] <= iomem_wstrb;
         log_wdata[log_n] <= iomem_wdata;
         log_cyc[log_n]   <= cyc;
         log_n            <= log_n + 1;
      end
      if (iomem_valid && pv &&
          (iomem_addr !== pa || iomem_wstrb !== ps || iomem_wdata !== pd))
         stab_err <= stab_err + 1;
      pv <= iomem_valid;
      pa <= iomem_addr;
      ps <= iomem_wstrb;
      pd <= iomem_wdata;
   end

   task automatic issue(input logic fill, input logic [31:0] src,
                        input logic [31:0] dst, input logic [15:0] len,
                        input logic [31:0] fd);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_fill = fill; cmd_src = src; cmd_dst = dst;
      cmd_len = len; cmd_fill_data = fd;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      $display("cmd fill=%0d src=%h dst=%h len=%0d fd=%h", fill, src, dst, len, fd);
   endtask

   task automatic wait_end(input int budget, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done || err) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags: busy/done/err got %b want 000", {busy, done, err}); end
      total++; if (iomem_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", iomem_valid); end
      total++; if ({iomem_addr, iomem_wstrb, iomem_wdata} !== 68'h0) begin bad++; $display("FAIL reset_bus: addr=%h wstrb=%h wdata=%h want all 0", iomem_addr, iomem_wstrb, iomem_wdata); end
      total++; if (words_done !== 16'd0) begin bad++; $display("FAIL reset_words_done: got %0d want 0", words_done); end
      resetn = 1'b1;
      $display("reset checked");
   endtask

   task automatic test_copy;
      logic [31:0] ea [0:5];
      logic [3:0]  es [0:5];
      logic [31:0] ed [0:5];
      int b, d0, e0, s0;
      bit seen;
      ea = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008};
      es = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
      ed = '{32'h0, 32'hA5A5_1000, 32'h0, 32'hA5A5_1004, 32'h0, 32'hA5A5_1008};
      resp_en = 1'b1;
      b = log_n; d0 = done_cnt; e0 = err_cnt; s0 = stab_err;
      issue(1'b0, 32'h1000, 32'h2000, 16'd3, 32'h0);
      @(negedge clk);
      total++; if (iomem_valid !== 1'b1 || iomem_addr !== 32'h1000 || iomem_wstrb !== 4'h0) begin bad++; $display("FAIL copy_first_beat: valid=%b addr=%h wstrb=%h want 1 00001000 0", iomem_valid, iomem_addr, iomem_wstrb); end
      wait_end(100, seen);
      total++; if (!seen) begin bad++; $display("FAIL copy_end: no done/err seen, want done"); end
      repeat (4) @(negedge clk);
      total++; if (log_n - b !== 6) begin bad++; $display("FAIL copy_beats: got %0d want 6", log_n - b); end
      for (int i = 0; i < 6; i++) begin
         total++;
         if (log_addr[b+i] !== ea[i] || log_wstrb[b+i] !== es[i] ||
             (es[i] == 4'hF && log_wdata[b+i] !== ed[i])) begin
            bad++;
            $display("FAIL copy_beat%0d: addr=%h wstrb=%h data=%h want addr=%h wstrb=%h data=%h",
                     i, log_addr[b+i], log_wstrb[b+i], log_wdata[b+i], ea[i], es[i], ed[i]);
         end
      end
      total++; if (done_cnt - d0 !== 1 || err_cnt !== e0) begin bad++; $display("FAIL copy_pulses: done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0); end
      total++; if (words_done !== 16'd3 || cmd_ready !== 1'b1) begin bad++; $display("FAIL copy_final: words_done=%0d cmd_ready=%b want 3 1", words_done, cmd_ready); end
      total++; if (stab_err !== s0) begin bad++; $display("FAIL copy_stable: %0d bus changes during valid, want 0", stab_err - s0); end
      $display("copy len=3 checked, beats=%0d", log_n - b);
   endtask

   task automatic test_fill;
      int b, d0, s0;
      bit seen;
      resp_en = 1'b1;
      b = log_n; d0 = done_cnt; s0 = stab_err;
      issue(1'b1, 32'h0, 32'h3000, 16'd4, 32'hDEAD_BEEF);
      wait_end(100, seen);
      total++; if (!seen) begin bad++; $display("FAIL fill_end: no done/err seen, want done"); end
      repeat (4) @(negedge clk);
      total++; if (log_n - b !== 4) begin bad++; $display("FAIL fill_beats: got %0d want 4", log_n - b); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (log_addr[b+i] !== 32'h3000 + 32'(4*i) || log_wstrb[b+i] !== 4'hF ||
             log_wdata[b+i] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL fill_beat%0d: addr=%h wstrb=%h data=%h want addr=%h wstrb=f data=deadbeef",
                     i, log_addr[b+i], log_wstrb[b+i], log_wdata[b+i], 32'h3000 + 32'(4*i));
         end
      end
      for (int i = 1; i < 4; i++) begin
         total++;
         if (log_cyc[b+i] - log_cyc[b+i-1] !== 3) begin
            bad++;
            $display("FAIL fill_spacing%0d: got %0d cycles between beats want 3", i, log_cyc[b+i] - log_cyc[b+i-1]);
         end
      end
      total++; if (done_cnt - d0 !== 1 || words_done !== 16'd4) begin bad++; $display("FAIL fill_final: done=%0d words_done=%0d want 1 4", done_cnt - d0, words_done); end
      total++; if (stab_err !== s0) begin bad++; $display("FAIL fill_stable: %0d bus changes during valid, want 0", stab_err - s0); end
      $display("fill len=4 checked, beats=%0d", log_n - b);
   endtask

   task automatic test_len0;
      int b, d0;
      b = log_n; d0 = done_cnt;
      issue(1'b0, 32'h100, 32'h200, 16'd0, 32'h0);
      @(negedge clk);
      total++; if (done !== 1'b1 || iomem_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL len0_pulse: done=%b valid=%b busy=%b want 1 0 0", done, iomem_valid, busy); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL len0_single: done=%b want 0", done); end
      repeat (5) @(negedge clk);
      total++; if (log_n !== b || done_cnt - d0 !== 1 || cmd_ready !== 1'b1) begin bad++; $display("FAIL len0_quiet: beats=%0d done=%0d cmd_ready=%b want 0 1 1", log_n - b, done_cnt - d0, cmd_ready); end
      $display("len=0 checked");
   endtask

   task automatic test_timeout;
      int d0, e0, vcnt;
      resp_en = 1'b0;
      d0 = done_cnt; e0 = err_cnt; vcnt = 0;
      issue(1'b0, 32'h4000, 32'h4100, 16'd2, 32'h0);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (iomem_valid) vcnt++;
         else break;
      end
      total++; if (vcnt !== 8) begin bad++; $display("FAIL timeout_valid_len: got %0d cycles want 8", vcnt); end
      total++; if (err !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL timeout_err: err=%b done=%b want 1 0", err, done); end
      total++; if (words_done !== 16'd0) begin bad++; $display("FAIL timeout_words: got %0d want 0", words_done); end
      repeat (3) @(negedge clk);
      total++; if (cmd_ready !== 1'b1 || err_cnt - e0 !== 1 || done_cnt !== d0) begin bad++; $display("FAIL timeout_final: cmd_ready=%b err=%0d done=%0d want 1 1 0", cmd_ready, err_cnt - e0, done_cnt - d0); end
      resp_en = 1'b1;
      $display("timeout checked, valid held %0d cycles", vcnt);
   endtask

   task automatic test_abort;
      int b, d0, e0;
      bit found, seen;
      resp_en = 1'b1;
      b = log_n; d0 = done_cnt; e0 = err_cnt; found = 1'b0;
      issue(1'b1, 32'h0, 32'h5000, 16'd5, 32'h1234_5678);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (log_n - b == 1 && iomem_valid) begin
            found = 1'b1;
            break;
         end
      end
      total++; if (!found) begin bad++; $display("FAIL abort_second_beat: second write not seen, want it on bus"); end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      wait_end(50, seen);
      total++; if (!seen) begin bad++; $display("FAIL abort_end: no done/err seen, want err"); end
      repeat (8) @(negedge clk);
      total++; if (log_n - b !== 2 || words_done !== 16'd2) begin bad++; $display("FAIL abort_count: beats=%0d words_done=%0d want 2 2", log_n - b, words_done); end
      total++; if (err_cnt - e0 !== 1 || done_cnt !== d0) begin bad++; $display("FAIL abort_pulses: err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0); end
      total++; if (busy !== 1'b0 || iomem_valid !== 1'b0) begin bad++; $display("FAIL abort_idle: busy=%b valid=%b want 0 0", busy, iomem_valid); end
      $display("abort in fill checked, words_done=%0d", words_done);
   endtask

   task automatic test_wrap_reset;
      logic [31:0] ea [0:3];
      logic [31:0] ed [0:3];
      int b, d0;
      bit seen;
      ea = '{32'h6000, 32'hFFFF_FFFC, 32'h6004, 32'h0000_0000};
      ed = '{32'h0, 32'hA5A5_6000, 32'h0, 32'hA5A5_6004};
      resp_en = 1'b1;
      b = log_n; d0 = done_cnt;
      issue(1'b0, 32'h6000, 32'hFFFF_FFFC, 16'd2, 32'h0);
      wait_end(100, seen);
      total++; if (!seen) begin bad++; $display("FAIL wrap_end: no done/err seen, want done"); end
      repeat (4) @(negedge clk);
      total++; if (log_n - b !== 4 || done_cnt - d0 !== 1) begin bad++; $display("FAIL wrap_beats: beats=%0d done=%0d want 4 1", log_n - b, done_cnt - d0); end
      for (int i = 1; i < 4; i += 2) begin
         total++;
         if (log_addr[b+i] !== ea[i] || log_wdata[b+i] !== ed[i]) begin
            bad++;
            $display("FAIL wrap_write%0d: addr=%h data=%h want addr=%h data=%h",
                     i, log_addr[b+i], log_wdata[b+i], ea[i], ed[i]);
         end
      end
      // Reset while a beat is stalled on the bus.
      resp_en = 1'b0;
      issue(1'b1, 32'h0, 32'h7000, 16'd3, 32'h55);
      repeat (3) @(negedge clk);
      total++; if (iomem_valid !== 1'b1) begin bad++; $display("FAIL rst_pre: valid=%b want 1", iomem_valid); end
      #2 resetn = 1'b0;
      #1;
      total++; if (iomem_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_beat: valid=%b cmd_ready=%b busy=%b want 0 1 0", iomem_valid, cmd_ready, busy); end
      @(negedge clk);
      resetn = 1'b1;
      resp_en = 1'b1;
      $display("address wrap and mid-beat reset checked");
   endtask

   initial begin
      test_reset;
      test_copy;
      test_fill;
      test_len0;
      test_timeout;
      test_abort;
      test_wrap_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
